id_hazard_req: RTL

Decode-stage hazard requester for the 5-stage RV32I pipeline. It keeps a shadow scoreboard of the instructions in the EX and MEM stages and raises `stallreq_id` toward the stall controller when the instruction in ID reads a register that an in-flight load has not yet produced. It reads the resulting `stall` vector back, so its scoreboard advances, holds or takes a bubble exactly as the real pipeline registers do. It also keeps a consecutive-stall watchdog and a total-stall performance counter.

---
 rtl/id_hazard_req_pkg.sv | 18 +
 rtl/id_hazard_req_hz_slot.sv | 15 +
 rtl/id_hazard_req.sv | 51 +++++
 3 files changed

// File: rtl/id_hazard_req_pkg.sv
// id_hazard_req_pkg: stall bus layout, scoreboard slot record and load-use match
package id_hazard_req_pkg;
  localparam int STALL_W = 8;
  localparam int STALL_IDEX = 2;
  localparam int STALL_EXMEM = 3;
  localparam int STALL_MEMWB = 4;
  localparam int REG_W = 5;
  typedef logic [REG_W-1:0] reg_addr_t;
  typedef struct packed {
    logic v;
    logic ld;
    reg_addr_t rd;
  } slot_t;
  typedef enum logic [1:0] {SLOT_HOLD, SLOT_LOAD, SLOT_BUBBLE} slot_op_t;
  function automatic logic slot_hit(slot_t s, logic rs1_ren, reg_addr_t rs1, logic rs2_ren, reg_addr_t rs2);
    return s.v & s.ld & (s.rd != '0) & ((rs1_ren & (rs1 == s.rd)) | (rs2_ren & (rs2 == s.rd)));
  endfunction
endpackage

// File: rtl/id_hazard_req_hz_slot.sv
// hz_slot: one {v, ld, rd} scoreboard register with load / bubble / hold select
module hz_slot
  import id_hazard_req_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] op,
  input  logic [6:0] d,
  output logic [6:0] q
);
  slot_op_t sel;
  assign sel = slot_op_t'(op);
  always_ff @(posedge clk)
    q <= !rst_n ? '0 : sel == SLOT_LOAD ? d : sel == SLOT_BUBBLE ? '0 : q;
endmodule

// File: rtl/id_hazard_req.sv
// id_hazard_req: decode-stage load-use hazard requester with stall watchdog and counter
module id_hazard_req
  import id_hazard_req_pkg::*;
#(
  parameter bit MEM_LOAD_FWD = 1'b1,
  parameter int WDOG_MAX = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  stall,
  input  logic        flush,
  input  logic        id_valid,
  input  logic        id_rs1_ren,
  input  logic        id_rs2_ren,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic        id_rd_we,
  input  logic        id_is_load,
  input  logic [4:0]  id_rd_addr,
  output logic        stallreq_id,
  output logic        wdog_err,
  output logic [3:0]  stall_streak,
  output logic [31:0] stall_total
);
  slot_t ex_q, mem_q, id_d;
  slot_op_t ex_op, mem_op;
  logic unused_stall;
  logic ex_hit, mem_hit;
  assign unused_stall = ^{stall[7:5], stall[1:0]};
  assign id_d = '{v: id_valid & id_rd_we, ld: id_is_load, rd: id_rd_addr};
  always_comb begin
    ex_op = !stall[STALL_IDEX] ? (flush ? SLOT_BUBBLE : SLOT_LOAD)
          : !stall[STALL_EXMEM] ? SLOT_BUBBLE : SLOT_HOLD;
    mem_op = !stall[STALL_EXMEM] ? SLOT_LOAD : !stall[STALL_MEMWB] ? SLOT_BUBBLE : SLOT_HOLD;
  end
  hz_slot u_ex (.clk(clk), .rst_n(rst_n), .op(ex_op), .d(id_d), .q(ex_q));
  hz_slot u_mem (.clk(clk), .rst_n(rst_n), .op(mem_op), .d(ex_q), .q(mem_q));
  assign ex_hit = slot_hit(ex_q, id_rs1_ren, id_rs1_addr, id_rs2_ren, id_rs2_addr);
  assign mem_hit = slot_hit(mem_q, id_rs1_ren, id_rs1_addr, id_rs2_ren, id_rs2_addr);
  assign stallreq_id = id_valid & ~flush & (ex_hit | (~MEM_LOAD_FWD & mem_hit));
  always_ff @(posedge clk)
    if (!rst_n) begin
      stall_streak <= '0;
      wdog_err <= 1'b0;
      stall_total <= '0;
    end else begin
      stall_streak <= stallreq_id ? stall_streak + 4'(stall_streak != 4'hF) : '0;
      wdog_err <= wdog_err | (stallreq_id & (int'(stall_streak) >= WDOG_MAX));
      stall_total <= stall_total + 32'(stallreq_id);
    end
endmodule
